// File: rtl/countdown_pkg.sv
// Shared types and constants for the MM:SS BCD countdown timer.
// Optional feature macro: AUTO_RELOAD_EN.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int          BCD_W        = 4;
  localparam logic [3:0]  SEC_TENS_MAX = 4'd5;
  localparam logic [3:0]  UNITS_MAX    = 4'd9;
  localparam logic [15:0] ZERO_TIME    = 16'h0000;
  localparam logic [15:0] ONE_SEC      = 16'h0001;

  // True when mm:ss is a legal BCD time with mm <= max_min.
  function automatic logic time_ok(
    input logic [7:0] mm,
    input logic [7:0] ss,
    input int         max_min
  );
    logic digits_ok;
    int   mval;
    digits_ok = (mm[7:4] <= UNITS_MAX) &&
                (mm[3:0] <= UNITS_MAX) &&
                (ss[7:4] <= SEC_TENS_MAX) &&
                (ss[3:0] <= UNITS_MAX);
    mval = int'(mm[7:4]) * 10 + int'(mm[3:0]);
    return digits_ok && (mval <= max_min);
  endfunction

endpackage

// File: rtl/countdown_timer_digit.sv
// One BCD down-counting digit; borrows to the next digit on 0->wrap.
// Four of these are chained to form the MM:SS value.
module bcd_down_digit
  import countdown_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_val,
  input  logic             dec_en,
  input  logic [BCD_W-1:0] wrap,
  output logic [BCD_W-1:0] digit,
  output logic             borrow_out
);

  assign borrow_out = dec_en && (digit == '0);

  // Digit register: reset, parallel load, or decrement with wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit <= '0;
    end else if (ld) begin
      digit <= ld_val;
    end else if (dec_en) begin
      if (digit == '0) digit <= wrap;
      else             digit <= digit - 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer: FSM, load checking, output pulses.
// Optional feature macro: AUTO_RELOAD_EN (reload shadow value at 00:00).
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       expired,
  output logic       done,
  output logic       load_err
);

`ifdef AUTO_RELOAD_EN
  localparam logic AUTO = 1'b1;
`else
  localparam logic AUTO = 1'b0;
`endif

  state_t      state;
  state_t      state_nx;
  logic        load_ok;
  logic        take_ld;
  logic        err_nx;
  logic        dec;
  logic        hit_zero;
  logic        at_zero;
  logic        at_one;
  logic        ld_en;
  logic [15:0] ld_val;
  logic        b_su;
  logic        b_st;
  logic        b_mu;
  logic        borrow_unused;

  assign at_zero = ({min_bcd, sec_bcd} == ZERO_TIME);
  assign at_one  = ({min_bcd, sec_bcd} == ONE_SEC);
  assign load_ok = time_ok(load_min, load_sec, MAX_MIN);

  // Request arbitration and next state: load > stop > start > tick.
  always_comb begin
    state_nx = state;
    take_ld  = 1'b0;
    err_nx   = 1'b0;
    dec      = 1'b0;
    hit_zero = 1'b0;
    if (load && state != RUN) begin
      if (load_ok) begin
        take_ld  = 1'b1;
        state_nx = IDLE;
      end else begin
        err_nx = 1'b1;
      end
    end else begin
      unique case (state)
        RUN: begin
          if (stop) begin
            state_nx = PAUSE;
          end else if (!start && tick) begin
            hit_zero = at_one;
            dec      = !(AUTO && at_one);
            if (at_one) state_nx = AUTO ? RUN : DONE;
          end
        end
        IDLE, PAUSE: begin
          if (start && !at_zero) state_nx = RUN;
        end
        DONE: begin
          state_nx = DONE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

`ifdef AUTO_RELOAD_EN
  logic [15:0] shadow;

  // Shadow copy of the last accepted load, replayed at 00:00.
  always_ff @(posedge clk) begin
    if (rst)          shadow <= ZERO_TIME;
    else if (take_ld) shadow <= {load_min, load_sec};
  end

  assign ld_en  = take_ld || hit_zero;
  assign ld_val = take_ld ? {load_min, load_sec} : shadow;
`else
  assign ld_en  = take_ld;
  assign ld_val = {load_min, load_sec};
`endif

  // State register and one-cycle output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nx;
      done     <= hit_zero;
      load_err <= err_nx;
    end
  end

  assign running = (state == RUN);
  assign expired = (state == DONE);

  bcd_down_digit u_sec_u (
    .clk        (clk),
    .rst        (rst),
    .ld         (ld_en),
    .ld_val     (ld_val[3:0]),
    .dec_en     (dec),
    .wrap       (UNITS_MAX),
    .digit      (sec_bcd[3:0]),
    .borrow_out (b_su)
  );

  bcd_down_digit u_sec_t (
    .clk        (clk),
    .rst        (rst),
    .ld         (ld_en),
    .ld_val     (ld_val[7:4]),
    .dec_en     (b_su),
    .wrap       (SEC_TENS_MAX),
    .digit      (sec_bcd[7:4]),
    .borrow_out (b_st)
  );

  bcd_down_digit u_min_u (
    .clk        (clk),
    .rst        (rst),
    .ld         (ld_en),
    .ld_val     (ld_val[11:8]),
    .dec_en     (b_st),
    .wrap       (UNITS_MAX),
    .digit      (min_bcd[3:0]),
    .borrow_out (b_mu)
  );

  bcd_down_digit u_min_t (
    .clk        (clk),
    .rst        (rst),
    .ld         (ld_en),
    .ld_val     (ld_val[15:12]),
    .dec_en     (b_mu),
    .wrap       (UNITS_MAX),
    .digit      (min_bcd[7:4]),
    .borrow_out (borrow_unused)
  );

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer.
// Build with AUTO_RELOAD_EN to exercise the reload variant.
module tb_countdown_timer;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       load;
  logic [7:0] load_min;
  logic [7:0] load_sec;
  logic       start;
  logic       stop;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       expired;
  logic       done;
  logic       load_err;

  countdown_timer #(.MAX_MIN(59)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .load     (load),
    .load_min (load_min),
    .load_sec (load_sec),
    .start    (start),
    .stop     (stop),
    .min_bcd  (min_bcd),
    .sec_bcd  (sec_bcd),
    .running  (running),
    .expired  (expired),
    .done     (done),
    .load_err (load_err)
  );

  // request bits {rst, load, stop, start, tick}
  localparam logic [4:0] N = 5'b00000;
  localparam logic [4:0] R = 5'b10000;
  localparam logic [4:0] L = 5'b01000;
  localparam logic [4:0] P = 5'b00100;
  localparam logic [4:0] S = 5'b00010;
  localparam logic [4:0] T = 5'b00001;

  // flags {running, expired, done, load_err}
  localparam logic [3:0] F0  = 4'b0000;
  localparam logic [3:0] FR  = 4'b1000;
  localparam logic [3:0] FX  = 4'b0100;
  localparam logic [3:0] FXD = 4'b0110;
  localparam logic [3:0] FRD = 4'b1010;
  localparam logic [3:0] FE  = 4'b0001;

  typedef struct {
    bit         c;
    logic [7:0] m;
    logic [7:0] s;
    logic [3:0] f;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Monitor: one expected entry per clock, compared after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      if (e.c) begin
        checks++;
        if ({min_bcd, sec_bcd, running, expired, done, load_err}
            !== {e.m, e.s, e.f}) begin
          errors++;
          $display("FAIL %s: got %h:%h flags=%b, expected %h:%h flags=%b",
                   e.nm, min_bcd, sec_bcd,
                   {running, expired, done, load_err},
                   e.m, e.s, e.f);
        end
      end
    end
  end

  task automatic go(
    input logic [4:0] r,
    input logic [7:0] lm,
    input logic [7:0] ls,
    input bit         c,
    input logic [7:0] em,
    input logic [7:0] es,
    input logic [3:0] ef,
    input string      nm
  );
    exp_t e;
    @(negedge clk);
    {rst, load, stop, start, tick} = r;
    load_min = lm;
    load_sec = ls;
    e.c  = c;
    e.m  = em;
    e.s  = es;
    e.f  = ef;
    e.nm = nm;
    q.push_back(e);
  endtask

  initial begin
    rst      = 1'b1;
    tick     = 1'b0;
    load     = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    load_min = 8'h00;
    load_sec = 8'h00;

    go(R, 8'h00, 8'h00, 1, 8'h00, 8'h00, F0, "reset");
    go(N, 8'h00, 8'h00, 1, 8'h00, 8'h00, F0, "reset_hold");

`ifndef AUTO_RELOAD_EN
    go(L, 8'h00, 8'h03, 1, 8'h00, 8'h03, F0, "t1_load");
    go(S, 8'h00, 8'h00, 1, 8'h00, 8'h03, FR, "t1_start");
    go(T, 8'h00, 8'h00, 1, 8'h00, 8'h02, FR, "t1_tick1");
    go(T, 8'h00, 8'h00, 1, 8'h00, 8'h01, FR, "t1_tick2");
    go(T, 8'h00, 8'h00, 1, 8'h00, 8'h00, FXD, "t1_done");
    go(N, 8'h00, 8'h00, 1, 8'h00, 8'h00, FX, "t1_expired");
    go(S, 8'h00, 8'h00, 1, 8'h00, 8'h00, FX, "t1_start_in_done");
    go(T, 8'h00, 8'h00, 1, 8'h00, 8'h00, FX, "t1_tick_in_done");
`else
    go(L, 8'h00, 8'h02, 1, 8'h00, 8'h02, F0, "t6_load");
    go(S, 8'h00, 8'h00, 1, 8'h00, 8'h02, FR, "t6_start");
    go(T, 8'h00, 8'h00, 1, 8'h00, 8'h01, FR, "t6_tick1");
    go(T, 8'h00, 8'h00, 1, 8'h00, 8'h02, FRD, "t6_reload1");
    go(T, 8'h00, 8'h00, 1, 8'h00, 8'h01, FR, "t6_tick3");
    go(T, 8'h00, 8'h00, 1, 8'h00, 8'h02, FRD, "t6_reload2");
    go(N, 8'h00, 8'h00, 1, 8'h00, 8'h02, FR, "t6_after");
`endif

    go(R, 8'h00, 8'h00, 1, 8'h00, 8'h00, F0, "t2_reset");
    go(L, 8'h02, 8'h00, 1, 8'h02, 8'h00, F0, "t2_load");
    go(S, 8'h00, 8'h00, 1, 8'h02, 8'h00, FR, "t2_start");
    go(T, 8'h00, 8'h00, 1, 8'h01, 8'h59, FR, "t2_borrow_min");
    for (int i = 0; i < 59; i++)
      go(T, 8'h00, 8'h00, 0, 8'h00, 8'h00, F0, "t2_run");
    go(T, 8'h00, 8'h00, 1, 8'h00, 8'h59, FR, "t2_60_more");
    go(P, 8'h00, 8'h00, 1, 8'h00, 8'h59, F0, "t2_stop");

    go(L, 8'h00, 8'h0A, 1, 8'h00, 8'h59, FE, "t3_sec_nibble");
    go(L, 8'h00, 8'h60, 1, 8'h00, 8'h59, FE, "t3_sec_tens");
    go(L, 8'h60, 8'h00, 1, 8'h00, 8'h59, FE, "t3_min_max");
    go(N, 8'h00, 8'h00, 1, 8'h00, 8'h59, F0, "t3_err_clear");
    go(S, 8'h00, 8'h00, 1, 8'h00, 8'h59, FR, "t3_still_paused");
    go(P, 8'h00, 8'h00, 1, 8'h00, 8'h59, F0, "t3_repause");
    go(L, 8'h59, 8'h59, 1, 8'h59, 8'h59, F0, "t3_max_ok");

    go(L, 8'h00, 8'h10, 1, 8'h00, 8'h10, F0, "t4_load");
    go(S, 8'h00, 8'h00, 1, 8'h00, 8'h10, FR, "t4_start");
    go(P|T, 8'h00, 8'h00, 1, 8'h00, 8'h10, F0, "t4_stop_tick");
    go(T, 8'h00, 8'h00, 1, 8'h00, 8'h10, F0, "t4_tick_paused");
    go(S, 8'h00, 8'h00, 1, 8'h00, 8'h10, FR, "t4_resume");
    go(T, 8'h00, 8'h00, 1, 8'h00, 8'h09, FR, "t4_tick");
    go(L, 8'h00, 8'h05, 1, 8'h00, 8'h09, FR, "t4_load_in_run");
    go(P|S, 8'h00, 8'h00, 1, 8'h00, 8'h09, F0, "t4_stop_start");

    go(L, 8'h10, 8'h00, 1, 8'h10, 8'h00, F0, "tb_load_10");
    go(S, 8'h00, 8'h00, 1, 8'h10, 8'h00, FR, "tb_start");
    go(T, 8'h00, 8'h00, 1, 8'h09, 8'h59, FR, "tb_min_tens");
    go(P, 8'h00, 8'h00, 1, 8'h09, 8'h59, F0, "tb_stop");

    go(L, 8'h01, 8'h30, 1, 8'h01, 8'h30, F0, "t5_load");
    go(S, 8'h00, 8'h00, 1, 8'h01, 8'h30, FR, "t5_start");
    go(T, 8'h00, 8'h00, 1, 8'h01, 8'h29, FR, "t5_tick");
    go(R|T, 8'h00, 8'h00, 1, 8'h00, 8'h00, F0, "t5_rst");
    go(T, 8'h00, 8'h00, 1, 8'h00, 8'h00, F0, "t5_tick_idle");
    go(S, 8'h00, 8'h00, 1, 8'h00, 8'h00, F0, "t5_start_zero");
    go(T, 8'h00, 8'h00, 1, 8'h00, 8'h00, F0, "t5_tick_after");

    go(N, 8'h00, 8'h00, 0, 8'h00, 8'h00, F0, "drain");
    for (int i = 0; i < 10 && q.size() != 0; i++)
      @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
